gen_if_xform_pipe: RTL and testbench

Parametrised successor to the generate-if copy/increment stage. It generalises data width, adds a selectable transform mode, a configurable-depth registered pipeline and a valid/ready handshake. Generate-if branches select the transform logic and the pipeline structure (STAGES=0 combinational, STAGES>=1 registered). It sits between producer and consumer datapaths wherever a fixed per-instance transform and retiming are needed.

---
 rtl/gen_if_xform_pipe.sv | 142 ++++++++++++++
 tb/tb_gen_if_xform_pipe.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_if_xform_pipe.sv
// Parametrised transform + retiming stage with valid/ready handshake.
// Optional statistics counters enabled by defining GEN_IF_XFORM_PIPE_STATS_EN.
module gen_if_xform_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
`ifdef GEN_IF_XFORM_PIPE_STATS_EN
  ,
  output logic [31:0]      xfer_cnt,
  output logic [31:0]      sat_cnt
`endif
);

  logic [WIDTH-1:0] xf_data;

  generate
    if (MODE == 0) begin : g_copy
      assign xf_data = in_data;
    end else if (MODE == 1) begin : g_wrap
      assign xf_data = in_data + WIDTH'(1);
    end else if (MODE == 2) begin : g_sat
      assign xf_data = (&in_data) ? in_data : in_data + WIDTH'(1);
    end else if (MODE == 3) begin : g_inv
      assign xf_data = ~in_data;
    end else begin : g_bad_mode
      $error("gen_if_xform_pipe: MODE must be 0..3");
      assign xf_data = in_data;
    end

    if (STAGES > 8 || CNT_W < $clog2(STAGES + 1)) begin : g_bad_cfg
      $error("gen_if_xform_pipe: STAGES must be 0..8 and fit in CNT_W");
    end
  endgenerate

  generate
    if (STAGES == 0) begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, flush};
      assign out_valid   = in_valid;
      assign in_ready    = out_ready;
      assign out_data    = xf_data;
      assign occupancy   = '0;
    end else begin : g_pipe
      logic              run_q;
      logic [STAGES-1:0] v_q, v_d;
      logic [WIDTH-1:0]  d_q [STAGES];
      logic [STAGES:0]   rdy;
      logic [CNT_W-1:0]  occ_q, occ_d;

      // Ready chain built with a running accumulator so no bit reads its own vector.
      always_comb begin
        logic acc;
        acc         = out_ready;
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int unsigned k = 0; k < STAGES; k++) begin
          acc                 = acc || !v_q[STAGES-1-k];
          rdy[STAGES-1-k]     = acc;
        end
      end

      // No input is taken in the first cycle after reset release nor during flush.
      assign in_ready = rdy[0] && run_q && !flush;

      always_comb begin
        v_d = v_q;
        if (flush) begin
          v_d = '0;
        end else begin
          if (rdy[0]) v_d[0] = in_valid && run_q;
          for (int unsigned i = 1; i < STAGES; i++) begin
            if (rdy[i]) v_d[i] = v_q[i-1];
          end
        end
      end

      always_comb begin
        occ_d = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
          occ_d = occ_d + CNT_W'(v_d[k]);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          run_q <= 1'b0;
          v_q   <= '0;
          occ_q <= '0;
          for (int unsigned i = 0; i < STAGES; i++) d_q[i] <= '0;
        end else begin
          run_q <= 1'b1;
          v_q   <= v_d;
          occ_q <= occ_d;
          if (rdy[0]) d_q[0] <= xf_data;
          for (int unsigned i = 1; i < STAGES; i++) begin
            if (rdy[i]) d_q[i] <= d_q[i-1];
          end
        end
      end

      assign out_valid = v_q[STAGES-1];
      assign out_data  = d_q[STAGES-1];
      assign occupancy = occ_q;
    end
  endgenerate

`ifdef GEN_IF_XFORM_PIPE_STATS_EN
  logic [31:0] xfer_cnt_q, sat_cnt_q;
  logic        sat_hit;

  assign sat_hit = (MODE == 2) && (&in_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= '0;
      sat_cnt_q  <= '0;
    end else if (flush) begin
      xfer_cnt_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      if (out_valid && out_ready) xfer_cnt_q <= xfer_cnt_q + 32'd1;
      if (in_valid && in_ready && sat_hit) sat_cnt_q <= sat_cnt_q + 32'd1;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
  assign sat_cnt  = sat_cnt_q;
`endif

endmodule

// File: tb/tb_gen_if_xform_pipe.sv
// Scoreboard bench for gen_if_xform_pipe: three instances cover registered wrap,
// registered saturate with backpressure/flush, and the combinational invert path.
module tb_gen_if_xform_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         vectors = 0;
  int         miscompares = 0;

  logic       a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [7:0] a_in_data = '0, a_out_data;
  logic [3:0] a_occupancy;
  logic       b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [7:0] b_in_data = '0, b_out_data;
  logic [3:0] b_occupancy;
  logic       c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0;
  logic [7:0] c_in_data = '0, c_out_data;
  logic [3:0] c_occupancy;
`ifdef GEN_IF_XFORM_PIPE_STATS_EN
  logic [31:0] a_xfer_cnt, a_sat_cnt, b_xfer_cnt, b_sat_cnt, c_xfer_cnt, c_sat_cnt;
`endif

  logic [7:0] qa[$], qb[$], qc[$];

  always #5 clk = ~clk;

  gen_if_xform_pipe #(.WIDTH(8), .STAGES(2), .MODE(1), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .occupancy(a_occupancy)
`ifdef GEN_IF_XFORM_PIPE_STATS_EN
    , .xfer_cnt(a_xfer_cnt), .sat_cnt(a_sat_cnt)
`endif
  );

  gen_if_xform_pipe #(.WIDTH(8), .STAGES(3), .MODE(2), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .occupancy(b_occupancy)
`ifdef GEN_IF_XFORM_PIPE_STATS_EN
    , .xfer_cnt(b_xfer_cnt), .sat_cnt(b_sat_cnt)
`endif
  );

  gen_if_xform_pipe #(.WIDTH(8), .STAGES(0), .MODE(3), .CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .occupancy(c_occupancy)
`ifdef GEN_IF_XFORM_PIPE_STATS_EN
    , .xfer_cnt(c_xfer_cnt), .sat_cnt(c_sat_cnt)
`endif
  );

  function automatic logic [7:0] xf(input int unsigned mode, input logic [7:0] d);
    case (mode)
      0:       return d;
      1:       return d + 8'd1;
      2:       return (d == 8'hFF) ? d : d + 8'd1;
      default: return ~d;
    endcase
  endfunction

  // Scoreboards: push on accepted input, pop on output transfer (both seen before the edge).
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n || a_flush) qa.delete();
    else begin
      if (a_in_valid && a_in_ready) qa.push_back(xf(1, a_in_data));
      if (a_out_valid && a_out_ready) begin
        vectors++;
        if (qa.size() == 0) begin
          miscompares++; $display("FAIL a_out_unexpected got %h required no output", a_out_data);
        end else begin
          e = qa.pop_front();
          if (a_out_data !== e) begin
            miscompares++; $display("FAIL a_out_data got %h required %h", a_out_data, e);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n || b_flush) qb.delete();
    else begin
      if (b_in_valid && b_in_ready) qb.push_back(xf(2, b_in_data));
      if (b_out_valid && b_out_ready) begin
        vectors++;
        if (qb.size() == 0) begin
          miscompares++; $display("FAIL b_out_unexpected got %h required no output", b_out_data);
        end else begin
          e = qb.pop_front();
          if (b_out_data !== e) begin
            miscompares++; $display("FAIL b_out_data got %h required %h", b_out_data, e);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) qc.delete();
    else begin
      if (c_in_valid && c_in_ready) qc.push_back(xf(3, c_in_data));
      if (c_out_valid && c_out_ready) begin
        vectors++;
        if (qc.size() == 0) begin
          miscompares++; $display("FAIL c_out_unexpected got %h required no output", c_out_data);
        end else begin
          e = qc.pop_front();
          if (c_out_data !== e) begin
            miscompares++; $display("FAIL c_out_data got %h required %h", c_out_data, e);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (3) tick();
    vectors++; if ({a_out_valid, a_out_data, a_occupancy} !== 13'd0) begin
      miscompares++; $display("FAIL reset_a got %h required 0", {a_out_valid, a_out_data, a_occupancy});
    end
    vectors++; if ({b_out_valid, b_out_data, b_occupancy} !== 13'd0) begin
      miscompares++; $display("FAIL reset_b got %h required 0", {b_out_valid, b_out_data, b_occupancy});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (a_in_ready !== 1'b0) begin
      miscompares++; $display("FAIL release_first_cycle_ready got %b required 0", a_in_ready);
    end
    tick();
    @(negedge clk);
    vectors++; if (a_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL release_second_cycle_ready got %b required 1", a_in_ready);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] w [3];
    logic [7:0] req [6];
    logic       vreq [6];
    w = '{8'h00, 8'h7F, 8'hFF};
    req = '{8'h00, 8'h00, 8'h01, 8'h80, 8'h00, 8'h00};
    vreq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    a_out_ready = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      a_in_valid = (k < 3);
      a_in_data  = (k < 3) ? w[k] : 8'h00;
      @(negedge clk);
      if (k < 3) begin
        vectors++; if (a_in_ready !== 1'b1) begin
          miscompares++; $display("FAIL wrap_in_ready[%0d] got %b required 1", k, a_in_ready);
        end
      end
      vectors++; if (a_out_valid !== vreq[k]) begin
        miscompares++; $display("FAIL wrap_out_valid[%0d] got %b required %b", k, a_out_valid, vreq[k]);
      end
      if (vreq[k]) begin
        vectors++; if (a_out_data !== req[k]) begin
          miscompares++; $display("FAIL wrap_out_data[%0d] got %h required %h", k, a_out_data, req[k]);
        end
      end
    end
  endtask

  task automatic test_saturate;
    b_out_ready = 1'b1;
    tick(); b_in_valid = 1'b1; b_in_data = 8'hFF;
    tick(); b_in_data = 8'hFE;
    tick(); b_in_valid = 1'b0;
    for (int unsigned k = 0; k < 20 && qb.size() != 0; k++) tick();
    vectors++; if (qb.size() != 0) begin
      miscompares++; $display("FAIL sat_drain got %0d pending required 0", qb.size());
    end
`ifdef GEN_IF_XFORM_PIPE_STATS_EN
    vectors++; if (b_sat_cnt !== 32'd1) begin
      miscompares++; $display("FAIL sat_cnt got %0d required 1", b_sat_cnt);
    end
    vectors++; if (a_sat_cnt !== 32'd0) begin
      miscompares++; $display("FAIL sat_cnt_wrap_mode got %0d required 0", a_sat_cnt);
    end
`endif
  endtask

  task automatic test_backpressure;
    logic [7:0] w [4];
    int unsigned idx = 0;
    w = '{8'h10, 8'h20, 8'h30, 8'h40};
    b_out_ready = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      tick();
      b_in_valid = (idx < 4);
      b_in_data  = w[idx[1:0]];
      @(negedge clk);
      if (b_in_valid && b_in_ready) idx++;
    end
    vectors++; if (idx != 3) begin
      miscompares++; $display("FAIL bp_accepted got %0d required 3", idx);
    end
    vectors++; if (b_in_ready !== 1'b0) begin
      miscompares++; $display("FAIL bp_in_ready got %b required 0", b_in_ready);
    end
    vectors++; if (b_occupancy !== 4'd3) begin
      miscompares++; $display("FAIL bp_occupancy got %0d required 3", b_occupancy);
    end
    for (int unsigned k = 0; k < 3; k++) begin
      tick(); @(negedge clk);
      vectors++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h11) begin
        miscompares++; $display("FAIL bp_hold[%0d] got %b/%h required 1/11", k, b_out_valid, b_out_data);
      end
    end
    tick(); b_out_ready = 1'b1;
    for (int unsigned k = 0; k < 20 && (idx < 4 || qb.size() != 0); k++) begin
      b_in_valid = (idx < 4);
      b_in_data  = w[idx[1:0]];
      @(negedge clk);
      if (b_in_valid && b_in_ready) idx++;
      tick();
    end
    b_in_valid = 1'b0;
    vectors++; if (idx != 4 || qb.size() != 0) begin
      miscompares++; $display("FAIL bp_release got %0d/%0d required 4/0", idx, qb.size());
    end
  endtask

  task automatic test_back_to_back;
    int unsigned idx = 0;
    b_out_ready = 1'b0;
    for (int unsigned k = 0; k < 10 && idx < 3; k++) begin
      tick();
      b_in_valid = 1'b1;
      b_in_data  = 8'h50 + 8'(idx);
      @(negedge clk);
      if (b_in_ready) idx++;
    end
    for (int unsigned k = 0; k < 10; k++) begin
      tick();
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_in_data   = 8'h60 + 8'(k);
      @(negedge clk);
      vectors++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b1 || b_occupancy !== 4'd3) begin
        miscompares++;
        $display("FAIL b2b[%0d] got rdy=%b vld=%b occ=%0d required 1/1/3", k, b_in_ready, b_out_valid, b_occupancy);
      end
    end
    tick(); b_in_valid = 1'b0;
    for (int unsigned k = 0; k < 20 && qb.size() != 0; k++) tick();
    vectors++; if (qb.size() != 0) begin
      miscompares++; $display("FAIL b2b_drain got %0d pending required 0", qb.size());
    end
  endtask

  task automatic test_flush;
    int unsigned idx = 0;
    b_out_ready = 1'b0;
    for (int unsigned k = 0; k < 10 && idx < 2; k++) begin
      tick();
      b_in_valid = 1'b1;
      b_in_data  = 8'h70 + 8'(idx);
      @(negedge clk);
      if (b_in_ready) idx++;
    end
    tick();
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h55;
    @(negedge clk);
    vectors++; if (b_occupancy !== 4'd2) begin
      miscompares++; $display("FAIL flush_pre_occ got %0d required 2", b_occupancy);
    end
    vectors++; if (b_in_ready !== 1'b0) begin
      miscompares++; $display("FAIL flush_in_ready got %b required 0", b_in_ready);
    end
    tick();
    b_flush = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (b_occupancy !== 4'd0 || b_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_clear got occ=%0d vld=%b required 0/0", b_occupancy, b_out_valid);
    end
`ifdef GEN_IF_XFORM_PIPE_STATS_EN
    vectors++; if (b_xfer_cnt !== 32'd0 || b_sat_cnt !== 32'd0) begin
      miscompares++; $display("FAIL flush_stats got %0d/%0d required 0/0", b_xfer_cnt, b_sat_cnt);
    end
`endif
    b_out_ready = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      tick(); @(negedge clk);
      vectors++; if (b_out_valid !== 1'b0) begin
        miscompares++; $display("FAIL flush_no_ghost[%0d] got %b required 0", k, b_out_valid);
      end
    end
    tick(); b_in_valid = 1'b1; b_in_data = 8'h33;
    tick(); b_in_valid = 1'b0;
    for (int unsigned k = 0; k < 20 && qb.size() != 0; k++) tick();
    vectors++; if (qb.size() != 0) begin
      miscompares++; $display("FAIL flush_recover got %0d pending required 0", qb.size());
    end
  endtask

  task automatic test_async_reset;
    a_out_ready = 1'b1;
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      a_in_valid = 1'b1;
      a_in_data  = 8'h20 + 8'(k);
    end
    @(posedge clk); #3;
    vectors++; if (a_out_valid !== 1'b1) begin
      miscompares++; $display("FAIL areset_pre_valid got %b required 1", a_out_valid);
    end
    rst_n = 1'b0;
    #1;
    vectors++; if ({a_out_valid, a_out_data, a_occupancy, a_in_ready} !== 14'd0) begin
      miscompares++;
      $display("FAIL areset_clear got vld=%b data=%h occ=%0d rdy=%b required 0", a_out_valid, a_out_data, a_occupancy, a_in_ready);
    end
    a_in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin
      miscompares++; $display("FAIL areset_release got rdy=%b vld=%b required 0/0", a_in_ready, a_out_valid);
    end
    tick(); @(negedge clk);
    vectors++; if (a_in_ready !== 1'b1) begin
      miscompares++; $display("FAIL areset_resume got %b required 1", a_in_ready);
    end
  endtask

  task automatic test_comb;
    logic [7:0] din [3];
    logic [7:0] dout [3];
    din  = '{8'hA5, 8'h00, 8'hFF};
    dout = '{8'h5A, 8'hFF, 8'h00};
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      c_in_valid = 1'b1; c_in_data = din[k]; c_out_ready = 1'b1;
      @(negedge clk);
      vectors++; if (c_out_valid !== 1'b1 || c_out_data !== dout[k] || c_in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL comb[%0d] got vld=%b data=%h rdy=%b required 1/%h/1", k, c_out_valid, c_out_data, c_in_ready, dout[k]);
      end
      #1;
      c_out_ready = 1'b0; c_in_valid = 1'b0;
      #1;
      vectors++; if (c_in_ready !== 1'b0 || c_out_valid !== 1'b0 || c_occupancy !== 4'd0) begin
        miscompares++;
        $display("FAIL comb_idle[%0d] got rdy=%b vld=%b occ=%0d required 0/0/0", k, c_in_ready, c_out_valid, c_occupancy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_comb();
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
